shift_load_ctrl: RTL and testbench

Upstream sequencer for the `nbit_shifter` stage. It accepts parallel words on a valid/ready handshake and buffers one pending word. For each word it drives the shifter's `inp`, `load` and `shift_ena` through one load cycle followed by a fixed number of shift cycles, then pulses `done`. Its outputs connect directly to the shifter ports of the same names, so software and test benches only have to present words, not sequence the shifter.

---
 rtl/shift_load_ctrl.sv | 111 +++++++++++
 tb/tb_shift_load_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_load_ctrl.sv
// shift_load_ctrl
// Upstream sequencer for the nbit_shifter stage. It accepts parallel words on
// a valid/ready handshake and keeps one word in a pending buffer. For each
// word it drives the shifter through one load cycle, then shift_count shift
// cycles, then a one-cycle done pulse.
//
// Parameters:
//   n           data width (must match the downstream shifter)
//   shift_count shift cycles per word, 1..255
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous, active-low reset
//   in_valid    upstream word present
//   in_data     upstream word
//   in_ready    pending buffer empty (accept on in_valid & in_ready)
//   pause       freezes shifting while 1 (only effective in SHIFT)
//   inp         word driven to the shifter, stable from LOAD to next drain
//   load        shifter parallel-load strobe
//   shift_ena   shifter shift enable
//   busy        sequencer is not idle
//   done        one-cycle pulse after the last shift cycle of a word
//   word_count  completed words, wraps 255 -> 0
module shift_load_ctrl #(
  parameter int n           = 16,
  parameter int shift_count = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [n-1:0] in_data,
  output logic         in_ready,
  input  logic         pause,
  output logic [n-1:0] inp,
  output logic         load,
  output logic         shift_ena,
  output logic         busy,
  output logic         done,
  output logic [7:0]   word_count
);

  localparam int cw = $clog2(shift_count + 1);
  // Counter value seen on the final unpaused SHIFT edge.
  localparam logic [cw-1:0] last_cnt = cw'(shift_count - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t         state;
  logic [n-1:0]   buf_data;
  logic           buf_full;
  logic [cw-1:0]  cnt;
  logic           accept;
  logic           drain;

  // Gated by reset so no word can be offered as accepted while in reset.
  assign in_ready = reset & ~buf_full;
  assign accept   = in_valid & in_ready;
  // A pending word is moved to the shifter from IDLE, or straight out of DONE
  // for back-to-back words. accept and drain never coincide: accept needs an
  // empty buffer, drain needs a full one.
  assign drain    = buf_full & ((state == IDLE) | (state == DONE));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      buf_data   <= '0;
      buf_full   <= 1'b0;
      cnt        <= '0;
      inp        <= '0;
      word_count <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register sees the
      // pre-edge value of the others, independent of statement order.
      if (accept) begin
        buf_data <= in_data;
        buf_full <= 1'b1;
      end else if (drain) begin
        buf_full <= 1'b0;
      end

      case (state)
        IDLE, DONE: begin
          if (drain) begin
            state <= LOAD;
            inp   <= buf_data;
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        LOAD: state <= SHIFT;
        SHIFT: begin
          if (!pause) begin
            cnt <= cnt + 1'b1;
            if (cnt == last_cnt) begin
              state      <= DONE;
              word_count <= word_count + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The shifter gives load priority, so shift_ena is also high during LOAD.
  assign load      = (state == LOAD);
  assign shift_ena = (state == LOAD) | ((state == SHIFT) & ~pause);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_shift_load_ctrl.sv
// tb_shift_load_ctrl
// Directed bench for shift_load_ctrl. Main instance uses n=16, shift_count=16;
// a second instance with shift_count=1 exercises word_count wrap-around.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_shift_load_ctrl;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        pause;
  logic [15:0] inp;
  logic        load;
  logic        shift_ena;
  logic        busy;
  logic        done;
  logic [7:0]  word_count;

  logic        w_in_valid;
  logic [15:0] w_in_data;
  logic        w_in_ready;
  logic [15:0] w_inp;
  logic        w_load;
  logic        w_shift_ena;
  logic        w_busy;
  logic        w_done;
  logic [7:0]  w_word_count;

  int checks = 0;
  int errors = 0;

  shift_load_ctrl #(.n(16), .shift_count(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .pause      (pause),
    .inp        (inp),
    .load       (load),
    .shift_ena  (shift_ena),
    .busy       (busy),
    .done       (done),
    .word_count (word_count)
  );

  shift_load_ctrl #(.n(16), .shift_count(1)) dut_wrap (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (w_in_valid),
    .in_data    (w_in_data),
    .in_ready   (w_in_ready),
    .pause      (1'b0),
    .inp        (w_inp),
    .load       (w_load),
    .shift_ena  (w_shift_ena),
    .busy       (w_busy),
    .done       (w_done),
    .word_count (w_word_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    in_valid = 1'b0;
    pause    = 1'b0;
    repeat (2) step();
    reset = 1'b1;
  endtask

  // Presents a word for one edge, then waits until the LOAD cycle.
  task automatic send_to_load(input logic [15:0] data);
    in_valid = 1'b1;
    in_data  = data;
    step();
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    int busy_cyc, shift_cyc, done_cnt, done_idx, paused_bad, done_seen;
    bit inp_stable;
    reset      = 1'b0;
    in_valid   = 1'b1;
    in_data    = 16'h5555;
    pause      = 1'b0;
    w_in_valid = 1'b0;
    w_in_data  = 16'h00FF;

    // ---------------- reset state, in_valid held high ----------------
    #20;
    check("rst_in_ready", in_ready, 0);
    check("rst_outputs", {load, shift_ena, busy, done}, 0);
    check("rst_inp", inp, 0);
    check("rst_word_count", word_count, 0);

    // ---------------- single word 16'h5555 ----------------
    @(negedge clock);
    reset = 1'b1;
    step();                           // accepted at this edge
    check("single_ready_drop", in_ready, 0);
    check("single_still_idle", busy, 0);
    in_valid = 1'b0;
    step();
    check("single_load", {load, shift_ena}, 2'b11);
    check("single_inp", inp, 16'h5555);
    busy_cyc = 1; shift_cyc = 0; done_cnt = 0; done_idx = 0; inp_stable = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (!busy) break;
      busy_cyc++;
      if (shift_ena && !load) shift_cyc++;
      if (done) begin done_cnt++; done_idx = busy_cyc; end
      if (inp !== 16'h5555) inp_stable = 1'b0;
    end
    check("single_shift_cycles", shift_cyc, 16);
    check("single_busy_cycles", busy_cyc, 18);
    check("single_done_count", done_cnt, 1);
    check("single_done_position", done_idx, 18);
    check("single_inp_stable", inp_stable, 1);
    check("single_word_count", word_count, 1);
    check("single_idle_ready", in_ready, 1);

    // ---------------- back-to-back ----------------
    do_reset();
    send_to_load(16'h5555);
    check("b2b_first_inp", inp, 16'h5555);
    repeat (3) step();                // now in SHIFT
    in_valid = 1'b1;
    in_data  = 16'hA0F3;
    check("b2b_ready_before", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("b2b_ready_after", in_ready, 0);
    check("b2b_inp_held", inp, 16'h5555);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin done_seen = 1; break; end
      step();
    end
    check("b2b_first_done", done_seen, 1);
    check("b2b_count_mid", word_count, 1);
    step();
    check("b2b_direct_load", {load, shift_ena, busy}, 3'b111);
    check("b2b_second_inp", inp, 16'hA0F3);
    check("b2b_ready_freed", in_ready, 1);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!busy) break;
      if (done) done_cnt++;
    end
    check("b2b_second_done", done_cnt, 1);
    check("b2b_word_count", word_count, 2);

    // ---------------- pause for 3 cycles mid-SHIFT ----------------
    do_reset();
    send_to_load(16'h1234);
    shift_cyc = 0; paused_bad = 0; done_idx = 0;
    for (int i = 1; i < 60; i++) begin
      step();
      pause = (i >= 6 && i <= 8);
      #1;
      if (done) begin done_idx = i; break; end
      if (pause && shift_ena) paused_bad++;
      if (shift_ena && !load) shift_cyc++;
    end
    pause = 1'b0;
    check("pause_ena_low", paused_bad, 0);
    check("pause_shift_total", shift_cyc, 16);
    check("pause_done_delay", done_idx, 20);

    // ---------------- reset mid-SHIFT with a buffered word ----------------
    do_reset();
    send_to_load(16'h00AA);
    step(); step();
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    step();
    in_valid = 1'b0;
    check("rmid_buffered", in_ready, 0);
    repeat (4) step();                // shift cycle 7
    check("rmid_shifting", shift_ena, 1);
    #2 reset = 1'b0;
    #1;
    check("rmid_outputs_clear", {load, shift_ena, busy, done, in_ready}, 0);
    check("rmid_inp_clear", inp, 0);
    check("rmid_count_clear", word_count, 0);
    done_seen = 0;
    repeat (3) begin step(); if (done) done_seen = 1; end
    reset = 1'b1;
    #1;
    check("rmid_ready_release", in_ready, 1);
    repeat (4) begin step(); if (done || busy) done_seen = 1; end
    check("rmid_word_lost", done_seen, 0);

    // ---------------- word_count wrap, shift_count = 1 ----------------
    do_reset();
    w_in_valid = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (w_done) begin
        done_cnt++;
        if (done_cnt == 255) check("wrap_255", w_word_count, 255);
        if (done_cnt == 256) begin
          check("wrap_0", w_word_count, 0);
          break;
        end
      end
    end
    w_in_valid = 1'b0;
    check("wrap_done_total", done_cnt, 256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
